// File: rtl/mprime_stream.sv
// Streams ML-DSA M' = prefix || len(ctx) || ctx || [OID] || msg as LANE_BYTES-wide beats.
// Define MPRIME_PREHASH_EN to honour `mode` (pre-hash prefix 0x01 plus OID insertion).
module mprime_stream #(
    parameter int unsigned MSG_MAX_BYTES = 3459,
    parameter int unsigned CTX_MAX_BYTES = 255,
    parameter int unsigned LANE_BYTES    = 8,
    parameter int unsigned OID_BYTES     = 11
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       mode,
    input  logic [CTX_MAX_BYTES*8-1:0] ctx,
    input  logic [8:0]                 ctx_len,
    input  logic [MSG_MAX_BYTES*8-1:0] msg,
    input  logic [15:0]                msg_len,
    input  logic [OID_BYTES*8-1:0]     oid,
    output logic [LANE_BYTES*8-1:0]    out_data,
    output logic [LANE_BYTES-1:0]      out_keep,
    output logic                       out_valid,
    output logic                       out_last,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       done,
    output logic                       err_ctx
);

    typedef enum logic [1:0] {StIdle, StStream, StFin, StErr} state_e;

    state_e state_q, state_d;
    logic [16:0] pos_q, pos_d;
    logic [16:0] len_q, len_d;
    logic        mode_q, mode_d;
    logic [8:0]  ctx_len_q, ctx_len_d;

    logic [LANE_BYTES*8-1:0] out_data_q, out_data_d;
    logic [LANE_BYTES-1:0]   out_keep_q, out_keep_d;
    logic out_valid_q, out_valid_d;
    logic out_last_q, out_last_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic err_q, err_d;

    logic        start_mode;
    logic        req_bad;
    logic [16:0] req_len;
    logic [16:0] ctx_end;
    logic [16:0] msg_base;
    logic [16:0] idx;
    logic [7:0]  byte_v;

`ifdef MPRIME_PREHASH_EN
    assign start_mode = mode;
`else
    logic unused_prehash;
    assign start_mode     = 1'b0;
    assign unused_prehash = ^{mode, oid};
`endif

    assign req_bad = (ctx_len > 9'd255) || (32'(ctx_len) > CTX_MAX_BYTES) ||
                     (32'(msg_len) > MSG_MAX_BYTES);
    assign req_len = 17'd2 + 17'(ctx_len) + (start_mode ? 17'(OID_BYTES) : 17'd0) +
                     17'(msg_len);

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        len_d     = len_q;
        mode_d    = mode_q;
        ctx_len_d = ctx_len_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    pos_d     = 17'd0;
                    len_d     = req_len;
                    mode_d    = start_mode;
                    ctx_len_d = ctx_len;
                    state_d   = req_bad ? StErr : StStream;
                end
            end
            StStream: begin
                if (out_ready) begin
                    if (out_last_q) state_d = StFin;
                    else            pos_d   = pos_q + 17'(LANE_BYTES);
                end
            end
            StFin:   state_d = StIdle;
            StErr:   state_d = StIdle;
        endcase

        // Next beat is built from the next-cycle pointer so every output leaves a flop.
        ctx_end    = 17'd2 + 17'(ctx_len_d);
        msg_base   = ctx_end + (mode_d ? 17'(OID_BYTES) : 17'd0);
        out_data_d = '0;
        out_keep_d = '0;
        out_last_d = 1'b0;
        idx        = 17'd0;
        byte_v     = 8'h00;
        if (state_d == StStream) begin
            for (int k = 0; k < int'(LANE_BYTES); k++) begin
                idx    = pos_d + 17'(k);
                byte_v = 8'h00;
                if (idx < len_d) begin
                    out_keep_d[k] = 1'b1;
                    if (idx == 17'd0)      byte_v = {7'b0, mode_d};
                    else if (idx == 17'd1) byte_v = ctx_len_d[7:0];
                    else if (idx < ctx_end) byte_v = ctx[8*(32'(idx) - 2) +: 8];
`ifdef MPRIME_PREHASH_EN
                    else if (idx < msg_base) byte_v = oid[8*32'(idx - ctx_end) +: 8];
`endif
                    else byte_v = msg[8*32'(idx - msg_base) +: 8];
                end
                out_data_d[8*k +: 8] = byte_v;
            end
            out_last_d = (pos_d + 17'(LANE_BYTES)) >= len_d;
        end
        out_valid_d = (state_d == StStream);
        busy_d      = (state_d != StIdle);
        done_d      = (state_d == StFin) || (state_d == StErr);
        err_d       = (state_d == StErr);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            pos_q       <= '0;
            len_q       <= '0;
            mode_q      <= 1'b0;
            ctx_len_q   <= '0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            len_q       <= len_d;
            mode_q      <= mode_d;
            ctx_len_q   <= ctx_len_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_keep  = out_keep_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err_ctx   = err_q;

endmodule
